fifo_rd_stream: RTL and testbench

- Read-domain drain stage that sits directly downstream of the async FIFO.
- Pops words from the FIFO read port (rinc/rEmpty/rData, one-cycle read latency) and presents them as a valid/ready stream through a 2-entry output buffer.
- Marks packet boundaries every PKT_LEN beats and counts transferred words.
- Runs entirely on rclk.

---
 rtl/fifo_rd_stream.sv | 131 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain drain stage for the async FIFO. It pops words through the
// FIFO read port (one-cycle read latency), holds them in a 2-entry output
// buffer and offers them downstream as a valid/ready stream with packet
// boundaries every PKT_LEN beats and a running handshake count.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 12,
  parameter int PKT_LEN   = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 rclk,
  input  logic                 wrst,
  input  logic                 enable,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // beat index is kept 16 bits wide so PKT_LEN up to 65535 always fits
  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic [1:0]           bufCnt_q, bufCnt_d;
  logic                 pending_q;
  logic [15:0]          beatIdx_q, beatIdx_d;
  logic [CNT_W-1:0]     wordCnt_q, wordCnt_d;

  logic                 pop;
  logic [2:0]           occ;
  logic [2:0]           occAfterPop;

  // Stream outputs and the pop request; a read is only issued when a slot
  // is guaranteed free by the time its data lands.
  always_comb begin
    m_valid     = (bufCnt_q != 2'd0);
    m_data      = head_q;
    m_last      = m_valid && (beatIdx_q == LAST_IDX);
    busy        = (state_q != IDLE);
    word_cnt    = wordCnt_q;
    pop         = m_valid && m_ready;
    occ         = {1'b0, bufCnt_q} + {2'b00, pending_q};
    occAfterPop = occ - {2'b00, pop};
    rinc        = (state_q == RUN) && !rEmpty && (occAfterPop < 3'd2);
  end

  // Buffer update: capture of the in-flight word and/or shift on pop.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    bufCnt_d = bufCnt_q;
    case ({pending_q, pop})
      2'b10: begin
        if (bufCnt_q == 2'd0) head_d = rData;
        else                  tail_d = rData;
        bufCnt_d = bufCnt_q + 2'd1;
      end
      2'b01: begin
        head_d   = tail_q;
        bufCnt_d = bufCnt_q - 2'd1;
      end
      2'b11: begin
        if (bufCnt_q == 2'd1) begin
          head_d = rData;
        end else begin
          head_d = tail_q;
          tail_d = rData;
        end
      end
      default: ;
    endcase
  end

  // Packet position and statistics advance on every handshake.
  always_comb begin
    beatIdx_d = beatIdx_q;
    wordCnt_d = wordCnt_q;
    if (pop) begin
      beatIdx_d = (beatIdx_q == LAST_IDX) ? 16'd0 : beatIdx_q + 16'd1;
      wordCnt_d = wordCnt_q + CNT_W'(1);
    end
  end

  // Run/drain control; drain finishes once nothing is buffered or in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                                   state_d = RUN;
        else if ((bufCnt_q == 2'd0) && !pending_q)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; reset discards buffered and in-flight words.
  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      bufCnt_q  <= 2'd0;
      pending_q <= 1'b0;
      beatIdx_q <= 16'd0;
      wordCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      bufCnt_q  <= bufCnt_d;
      pending_q <= rinc;
      beatIdx_q <= beatIdx_d;
      wordCnt_q <= wordCnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a default instance (PKT_LEN=16) and a
// PKT_LEN=1 / CNT_W=4 instance, each fed by a small registered FIFO model.
module tb_fifo_rd_stream;

  localparam int PKT = 16;

  logic        rclk;
  logic        wrst;

  logic        enable0, rEmpty0, rinc0, m_valid0, m_ready0, m_last0, busy0;
  logic [11:0] rData0, m_data0;
  logic [15:0] word_cnt0;

  logic        enable1, rEmpty1, rinc1, m_valid1, m_ready1, m_last1, busy1;
  logic [11:0] rData1, m_data1;
  logic [3:0]  word_cnt1;

  logic        wrReq0, wrReq1;
  logic [11:0] wrData0, wrData1;
  logic [11:0] mem0 [256];
  logic [11:0] mem1 [256];
  logic [7:0]  wp0, rp0, wn0, rn0, wp1, rp1, wn1, rn1;

  int assertCount = 0;
  int failCount   = 0;
  int tbBuf, tbPend, hs0;
  int lastSeen    = 0;
  int beats1      = 0;

  logic [11:0] wrQ0[$], expQ0[$], wrQ1[$], expQ1[$];
  logic        stallPrev;
  logic [11:0] prevData;
  logic        prevLast;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        expRinc;
    logic        expValid;
    logic [11:0] expData;
    logic        expLast;
    logic        expBusy;
  } vec_t;

  vec_t vecs[46];

  fifo_rd_stream dut (
    .rclk(rclk), .wrst(wrst), .enable(enable0), .rEmpty(rEmpty0),
    .rData(rData0), .rinc(rinc0), .m_valid(m_valid0), .m_ready(m_ready0),
    .m_data(m_data0), .m_last(m_last0), .busy(busy0), .word_cnt(word_cnt0)
  );

  fifo_rd_stream #(.DATA_SIZE(12), .PKT_LEN(1), .CNT_W(4)) dut1 (
    .rclk(rclk), .wrst(wrst), .enable(enable1), .rEmpty(rEmpty1),
    .rData(rData1), .rinc(rinc1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_last(m_last1), .busy(busy1), .word_cnt(word_cnt1)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  assign wn0 = wp0 + 8'(wrReq0);
  assign rn0 = rp0 + 8'(rinc0 && !rEmpty0);
  assign wn1 = wp1 + 8'(wrReq1);
  assign rn1 = rp1 + 8'(rinc1 && !rEmpty1);

  // FIFO model for instance 0: registered empty flag, one-cycle read data
  always @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      wp0 <= 8'd0; rp0 <= 8'd0; rEmpty0 <= 1'b1; rData0 <= 12'd0;
    end else begin
      if (wrReq0) mem0[wp0] <= wrData0;
      if (rinc0 && !rEmpty0) rData0 <= mem0[rp0];
      wp0 <= wn0; rp0 <= rn0; rEmpty0 <= (wn0 == rn0);
    end
  end

  // FIFO model for instance 1
  always @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      wp1 <= 8'd0; rp1 <= 8'd0; rEmpty1 <= 1'b1; rData1 <= 12'd0;
    end else begin
      if (wrReq1) mem1[wp1] <= wrData1;
      if (rinc1 && !rEmpty1) rData1 <= mem1[rp1];
      wp1 <= wn1; rp1 <= rn1; rEmpty1 <= (wn1 == rn1);
    end
  end

  // Occupancy and handshake bookkeeping for instance 0, from its own ports
  always @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      tbBuf <= 0; tbPend <= 0; hs0 <= 0;
    end else begin
      tbBuf  <= tbBuf + tbPend - int'(m_valid0 && m_ready0);
      tbPend <= int'(rinc0);
      if (m_valid0 && m_ready0) hs0 <= hs0 + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic queueWrite0(input logic [11:0] d);
    wrQ0.push_back(d);
    expQ0.push_back(d);
  endtask

  // Per-cycle scoreboard and protocol checks for instance 0
  task automatic cycleCheck0();
    logic pop;
    pop = m_valid0 && m_ready0;
    check("valid_vs_occ", 32'(m_valid0), 32'(tbBuf != 0));
    check("occ_max", 32'(tbBuf + tbPend <= 2), 32'd1);
    if (rinc0) check("rinc_slot", 32'(tbBuf + tbPend - int'(pop) < 2), 32'd1);
    if (rEmpty0) check("rinc_empty", 32'(rinc0), 32'd0);
    if (stallPrev) begin
      check("hold_valid", 32'(m_valid0), 32'd1);
      check("hold_data", 32'(m_data0), 32'(prevData));
      check("hold_last", 32'(m_last0), 32'(prevLast));
    end
    if (pop) begin
      if (expQ0.size() == 0) begin
        check("extra_beat", 32'(m_data0), 32'hFFFF_FFFF);
      end else begin
        check("beat_data", 32'(m_data0), 32'(expQ0.pop_front()));
      end
      check("beat_last", 32'(m_last0), 32'((hs0 % PKT) == PKT - 1));
      if (m_last0) lastSeen++;
    end
    stallPrev = m_valid0 && !m_ready0;
    prevData  = m_data0;
    prevLast  = m_last0;
  endtask

  task automatic driveCycle0(input logic en, input logic rdy);
    @(negedge rclk);
    enable0  = en;
    m_ready0 = rdy;
    if (wrQ0.size() > 0) begin
      wrReq0  = 1'b1;
      wrData0 = wrQ0.pop_front();
    end else begin
      wrReq0 = 1'b0;
    end
    #1;
    cycleCheck0();
  endtask

  task automatic driveCycle1(input logic en, input logic rdy);
    @(negedge rclk);
    enable1  = en;
    m_ready1 = rdy;
    if (wrQ1.size() > 0) begin
      wrReq1  = 1'b1;
      wrData1 = wrQ1.pop_front();
    end else begin
      wrReq1 = 1'b0;
    end
    #1;
    if (en) check("p1_last_eq_valid", 32'(m_last1), 32'(m_valid1));
    if (m_valid1 && m_ready1) begin
      beats1++;
      if (expQ1.size() == 0) check("p1_extra_beat", 32'(m_data1), 32'hFFFF_FFFF);
      else                   check("p1_data", 32'(m_data1), 32'(expQ1.pop_front()));
    end
  endtask

  task automatic checkOutput(input int i);
    check($sformatf("v%0d_rinc", i), 32'(rinc0), 32'(vecs[i].expRinc));
    check($sformatf("v%0d_valid", i), 32'(m_valid0), 32'(vecs[i].expValid));
    check($sformatf("v%0d_busy", i), 32'(busy0), 32'(vecs[i].expBusy));
    check($sformatf("v%0d_last", i), 32'(m_last0), 32'(vecs[i].expLast));
    if (vecs[i].expValid) check($sformatf("v%0d_data", i), 32'(m_data0), 32'(vecs[i].expData));
  endtask

  task automatic applyStimulus(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      driveCycle0(vecs[i].en, vecs[i].rdy);
      checkOutput(i);
    end
  endtask

  function automatic vec_t mkVec(input logic en, input logic rdy, input logic r,
                                 input logic v, input logic [11:0] d,
                                 input logic l, input logic b);
    vec_t t;
    t.en = en; t.rdy = rdy; t.expRinc = r; t.expValid = v;
    t.expData = d; t.expLast = l; t.expBusy = b;
    return t;
  endfunction

  initial begin
    int lastBefore;

    // streaming vectors: enable sampled at k=0, rinc from k=1, beats k=3..34
    for (int k = 0; k < 36; k++) begin
      logic v;
      v = (k >= 3) && (k <= 34);
      vecs[k] = mkVec(1'b1, 1'b1, (k >= 1) && (k <= 32), v,
                      v ? 12'(k - 2) : 12'd0,
                      v && (((k - 2) % 16) == 0), k >= 1);
    end
    // drain: buffer full (0x301,0x302), 0x303/0x304 still in the FIFO
    vecs[36] = mkVec(1'b0, 1'b0, 1'b0, 1'b1, 12'h301, 1'b0, 1'b1);
    vecs[37] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 12'h301, 1'b0, 1'b1);
    vecs[38] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 12'h302, 1'b0, 1'b1);
    vecs[39] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    vecs[40] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    vecs[41] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
    vecs[42] = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
    vecs[43] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 12'h303, 1'b0, 1'b1);
    vecs[44] = mkVec(1'b1, 1'b1, 1'b0, 1'b1, 12'h304, 1'b0, 1'b1);
    vecs[45] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);

    wrst = 1'b0;
    enable0 = 1'b0; m_ready0 = 1'b1; wrReq0 = 1'b0; wrData0 = 12'd0;
    enable1 = 1'b0; m_ready1 = 1'b1; wrReq1 = 1'b0; wrData1 = 12'd0;
    stallPrev = 1'b0; prevData = 12'd0; prevLast = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid0), 32'd0);
    check("rst_data", 32'(m_data0), 32'd0);
    check("rst_last", 32'(m_last0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rinc", 32'(rinc0), 32'd0);
    check("rst_cnt", 32'(word_cnt0), 32'd0);
    repeat (2) @(negedge rclk);
    wrst = 1'b1;

    $display("[TB] streaming");
    for (int i = 1; i <= 32; i++) queueWrite0(12'(i));
    repeat (33) driveCycle0(1'b0, 1'b1);
    applyStimulus(0, 35);
    check("stream_cnt", 32'(word_cnt0), 32'd32);

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) queueWrite0(12'h101 + 12'(i));
    for (int c = 0; c < 40; c++) driveCycle0(1'b1, (c % 4 == 0) || (c % 4 == 3));
    check("bp_delivered", 32'(expQ0.size()), 32'd0);
    check("bp_hs", 32'(hs0), 32'd40);

    $display("[TB] empty boundary");
    for (int i = 0; i < 3; i++) queueWrite0(12'h201 + 12'(i));
    repeat (12) driveCycle0(1'b1, 1'b1);
    check("empty_hs", 32'(hs0), 32'd43);
    check("empty_valid", 32'(m_valid0), 32'd0);
    lastBefore = lastSeen;
    for (int i = 3; i < 8; i++) queueWrite0(12'h201 + 12'(i));
    repeat (14) driveCycle0(1'b1, 1'b1);
    check("resume_hs", 32'(hs0), 32'd48);
    check("resume_last", 32'(lastSeen - lastBefore), 32'd1);

    $display("[TB] drain");
    for (int i = 0; i < 4; i++) queueWrite0(12'h301 + 12'(i));
    repeat (6) driveCycle0(1'b1, 1'b0);
    applyStimulus(36, 45);
    check("drain_cnt", 32'(word_cnt0), 32'd52);

    $display("[TB] PKT_LEN=1, CNT_W=4");
    for (int i = 0; i < 18; i++) begin
      wrQ1.push_back(12'h401 + 12'(i));
      expQ1.push_back(12'h401 + 12'(i));
    end
    repeat (19) driveCycle1(1'b0, 1'b1);
    repeat (24) driveCycle1(1'b1, 1'b1);
    check("p1_beats", 32'(beats1), 32'd18);
    check("p1_cnt_wrap", 32'(word_cnt1), 32'd2);
    check("p1_valid_end", 32'(m_valid1), 32'd0);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 6; i++) queueWrite0(12'h501 + 12'(i));
    repeat (8) driveCycle0(1'b1, 1'b0);
    check("pre_rst_valid", 32'(m_valid0), 32'd1);
    @(negedge rclk);
    #2;
    wrst = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid0), 32'd0);
    check("arst_last", 32'(m_last0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_cnt", 32'(word_cnt0), 32'd0);
    check("arst_rinc", 32'(rinc0), 32'd0);
    check("arst_cnt1", 32'(word_cnt1), 32'd0);
    wrQ0.delete();
    expQ0.delete();
    stallPrev = 1'b0;
    wrReq0 = 1'b0;
    @(negedge rclk);
    wrst = 1'b1;
    lastBefore = lastSeen;
    for (int i = 0; i < 16; i++) queueWrite0(12'h601 + 12'(i));
    repeat (24) driveCycle0(1'b1, 1'b1);
    check("post_rst_hs", 32'(hs0), 32'd16);
    check("post_rst_cnt", 32'(word_cnt0), 32'd16);
    check("post_rst_last", 32'(lastSeen - lastBefore), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
